// File: rtl/tomasulo_cdb_arb.sv
// Common data bus arbiter: one holding slot per execution unit, round-robin
// grant among occupied slots, registered single-word CDB broadcast.
module tomasulo_cdb_arb #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 4,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [N_REQ-1:0]             req_vld,
    input  logic [N_REQ-1:0][TAG_W-1:0]  req_tag,
    input  logic [N_REQ-1:0][W-1:0]      req_wdata,
    output logic [N_REQ-1:0]             req_rdy,
    output logic                         cdb_vld_r,
    output logic [TAG_W-1:0]             cdb_tag_r,
    output logic [W-1:0]                 cdb_wdata_r
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N_REQ);

    logic [N_REQ-1:0]             slot_vld_q, slot_vld_d;
    logic [N_REQ-1:0][TAG_W-1:0]  slot_tag_q, slot_tag_d;
    logic [N_REQ-1:0][W-1:0]      slot_data_q, slot_data_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic                         cdb_vld_q, cdb_vld_d;
    logic [TAG_W-1:0]             cdb_tag_q, cdb_tag_d;
    logic [W-1:0]                 cdb_data_q, cdb_data_d;

    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             accept;
    logic                         gnt_any;
    logic [PTR_W-1:0]             gnt_idx;
    logic [PTR_W:0]               idx_sum;
    logic [PTR_W:0]               ptr_inc;

    // Scan occupied slots starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (idx_sum >= N_EXT) begin
                idx_sum = idx_sum - N_EXT;
            end
            if (!gnt_any && !flush && slot_vld_q[idx_sum[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_sum[PTR_W-1:0];
            end
        end
        gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    end

    // A granted slot frees itself this cycle, so its unit may refill it.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rdy
        assign req_rdy[gi] = (~slot_vld_q[gi] | gnt[gi]) & ~rst & ~flush;
        assign accept[gi]  = req_vld[gi] & req_rdy[gi];
    end

    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_tag_d  = slot_tag_q;
        slot_data_d = slot_data_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (flush) begin
                slot_vld_d[i] = 1'b0;
            end else if (accept[i]) begin
                slot_vld_d[i]  = 1'b1;
                slot_tag_d[i]  = req_tag[i];
                slot_data_d[i] = req_wdata[i];
            end else if (gnt[i]) begin
                slot_vld_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        ptr_inc = {1'b0, gnt_idx} + (PTR_W + 1)'(1);
        ptr_d   = ptr_q;
        if (gnt_any) begin
            ptr_d = (ptr_inc == N_EXT) ? '0 : ptr_inc[PTR_W-1:0];
        end
        cdb_vld_d  = gnt_any;
        cdb_tag_d  = gnt_any ? slot_tag_q[gnt_idx]  : '0;
        cdb_data_d = gnt_any ? slot_data_q[gnt_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q  <= '0;
            slot_tag_q  <= '0;
            slot_data_q <= '0;
            ptr_q       <= '0;
            cdb_vld_q   <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_tag_q  <= slot_tag_d;
            slot_data_q <= slot_data_d;
            ptr_q       <= ptr_d;
            cdb_vld_q   <= cdb_vld_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_vld_r   = cdb_vld_q;
    assign cdb_tag_r   = cdb_tag_q;
    assign cdb_wdata_r = cdb_data_q;

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// Bench for tomasulo_cdb_arb: directed vector table, a fairness sequence and
// randomized traffic compared against a per-unit mailbox model.
module tb_tomasulo_cdb_arb;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [3:0]       req_vld = '0;
    logic [3:0][3:0]  req_tag = '0;
    logic [3:0][31:0] req_wdata = '0;
    logic [3:0]       req_rdy;
    logic             cdb_vld_r;
    logic [3:0]       cdb_tag_r;
    logic [31:0]      cdb_wdata_r;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tomasulo_cdb_arb #(.N_REQ(4), .TAG_W(4), .W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_vld    (req_vld),
        .req_tag    (req_tag),
        .req_wdata  (req_wdata),
        .req_rdy    (req_rdy),
        .cdb_vld_r  (cdb_vld_r),
        .cdb_tag_r  (cdb_tag_r),
        .cdb_wdata_r(cdb_wdata_r)
    );

    typedef struct {
        logic        r;
        logic        f;
        logic [3:0]  v;
        logic [15:0] t;
        logic [31:0] db;
        logic [3:0]  erdy;
        logic        evld;
        logic [3:0]  etag;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v,
                                input logic [15:0] t, input logic [31:0] db,
                                input logic [3:0] erdy, input logic evld,
                                input logic [3:0] etag, input logic [31:0] edata);
        vec_t x;
        x.r = r; x.f = f; x.v = v; x.t = t; x.db = db;
        x.erdy = erdy; x.evld = evld; x.etag = etag; x.edata = edata;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Unit i carries tag nibble i of t and data db + i*0x1000_0000.
    task automatic drive(input logic r, input logic f, input logic [3:0] v,
                         input logic [15:0] t, input logic [31:0] db);
        @(negedge clk);
        rst = r;
        flush = f;
        req_vld = v;
        for (int i = 0; i < N; i++) begin
            req_tag[i]   = t[4*i +: 4];
            req_wdata[i] = db + 32'(i) * 32'h1000_0000;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mailbox model state
    logic        m_occ [N];
    logic [3:0]  m_tag [N];
    logic [31:0] m_dat [N];
    int          m_ptr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // reset
        tbl.push_back(mk(1,0,4'b0000,16'h0000,32'h0,          4'b0000,0,4'h0,32'h0));
        // single request, unit 2
        tbl.push_back(mk(0,0,4'b0100,16'h0500,32'hBEADBEEF,   4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,1,4'h5,32'hDEADBEEF));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,0,4'h0,32'h0));
        // reset, then all four collide with ptr 0
        tbl.push_back(mk(1,0,4'b0000,16'h0000,32'h0,          4'b0000,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b1111,16'h4321,32'h100,        4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b0001,1,4'h1,32'h00000100));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b0011,1,4'h2,32'h10000100));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b0111,1,4'h3,32'h20000100));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,1,4'h4,32'h30000100));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,0,4'h0,32'h0));
        // back-to-back on unit 1 (grant and refill)
        tbl.push_back(mk(0,0,4'b0010,16'h0070,32'h07000000,   4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0010,16'h0080,32'h08000000,   4'b1111,1,4'h7,32'h17000000));
        tbl.push_back(mk(0,0,4'b0010,16'h0090,32'h09000000,   4'b1111,1,4'h8,32'h18000000));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,1,4'h9,32'h19000000));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,0,4'h0,32'h0));
        // flush with slots 0,1 occupied; unit 2 offers during flush and is refused
        tbl.push_back(mk(0,0,4'b0011,16'h00BA,32'h000000F0,   4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,1,4'b0100,16'h0D00,32'h00000DD0,   4'b0000,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0001,16'h000C,32'h00000CC0,   4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,1,4'hC,32'h00000CC0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,0,4'h0,32'h0));
        // move ptr to 3, then reset with three slots occupied
        tbl.push_back(mk(0,0,4'b0100,16'h0600,32'h00000060,   4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,1,4'h6,32'h20000060));
        tbl.push_back(mk(0,0,4'b0111,16'h0321,32'h00000AA0,   4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(1,0,4'b0001,16'h000F,32'h00000FF0,   4'b0000,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,0,4'h0,32'h0));
        // ptr must be back at 0: unit 1 wins before unit 3
        tbl.push_back(mk(0,0,4'b1010,16'hB0A0,32'h00000BB0,   4'b1111,0,4'h0,32'h0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b0111,1,4'hA,32'h10000BB0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,1,4'hB,32'h30000BB0));
        tbl.push_back(mk(0,0,4'b0000,16'h0000,32'h0,          4'b1111,0,4'h0,32'h0));

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].r, tbl[n].f, tbl[n].v, tbl[n].t, tbl[n].db);
            chk($sformatf("vec%0d_rdy", n), 32'(req_rdy), 32'(tbl[n].erdy));
            tick();
            chk($sformatf("vec%0d_cdb_vld", n), 32'(cdb_vld_r), 32'(tbl[n].evld));
            chk($sformatf("vec%0d_cdb_tag", n), 32'(cdb_tag_r), 32'(tbl[n].etag));
            chk($sformatf("vec%0d_cdb_data", n), cdb_wdata_r, tbl[n].edata);
            $display("vec %0d: rst=%0b flush=%0b vld=%b rdy=%b -> cdb vld=%0b tag=%h data=%h",
                     n, tbl[n].r, tbl[n].f, tbl[n].v, req_rdy, cdb_vld_r, cdb_tag_r, cdb_wdata_r);
        end

        // Fairness: units 0 and 3 request continuously, grants alternate 0,3,0,3.
        begin
            int cnt0 = 0, cnt3 = 0, exp0 = 0, exp3 = 0;
            logic [3:0] rdy_s;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                rst = 1'b0;
                flush = 1'b0;
                req_vld = 4'b1001;
                req_tag = '0;
                req_wdata = '0;
                req_tag[0] = 4'(cnt0);
                req_tag[3] = 4'(cnt3);
                req_wdata[0] = {16'd0, 16'(cnt0)};
                req_wdata[3] = {16'd3, 16'(cnt3)};
                #1;
                rdy_s = req_rdy;
                chk($sformatf("fair%0d_rdy", k), 32'(req_rdy),
                    (k == 0) ? 32'hF : ((k % 2 == 1) ? 32'h7 : 32'hE));
                tick();
                if (k >= 1) begin
                    int eu;
                    int ec;
                    eu = (k % 2 == 1) ? 0 : 3;
                    ec = (eu == 0) ? exp0 : exp3;
                    chk($sformatf("fair%0d_vld", k), 32'(cdb_vld_r), 32'd1);
                    chk($sformatf("fair%0d_data", k), cdb_wdata_r, {16'(eu), 16'(ec)});
                    chk($sformatf("fair%0d_tag", k), 32'(cdb_tag_r), 32'(4'(ec)));
                    if (eu == 0) exp0++; else exp3++;
                end else begin
                    chk("fair0_vld", 32'(cdb_vld_r), 32'd0);
                end
                if (rdy_s[0]) cnt0++;
                if (rdy_s[3]) cnt3++;
                $display("fair %0d: rdy=%b -> cdb vld=%0b tag=%h data=%h",
                         k, rdy_s, cdb_vld_r, cdb_tag_r, cdb_wdata_r);
            end
        end

        // Randomized traffic against the mailbox model.
        drive(1, 0, 4'b0000, 16'h0, 32'h0);
        tick();
        for (int i = 0; i < N; i++) begin
            m_occ[i] = 1'b0;
            m_tag[i] = '0;
            m_dat[i] = '0;
        end
        m_ptr = 0;
        for (int c = 0; c < 500; c++) begin
            logic r, f;
            logic [3:0] v;
            logic [3:0] exp_rdy;
            int win;
            logic e_vld;
            logic [3:0] e_tag;
            logic [31:0] e_dat;
            r = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 15) == 0);
            v = 4'($urandom);
            @(negedge clk);
            rst = r;
            flush = f;
            req_vld = v;
            for (int i = 0; i < N; i++) begin
                req_tag[i]   = 4'($urandom);
                req_wdata[i] = $urandom;
            end
            #1;
            // Oldest-turn mailbox: first waiting unit at or after the turn pointer.
            win = -1;
            if (!r && !f) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && m_occ[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                exp_rdy[i] = !r && !f && (!m_occ[i] || win == i);
            end
            chk($sformatf("rnd%0d_rdy", c), 32'(req_rdy), 32'(exp_rdy));
            tick();
            e_vld = 1'b0;
            e_tag = '0;
            e_dat = '0;
            if (r) begin
                for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
                m_ptr = 0;
            end else begin
                if (win >= 0) begin
                    e_vld = 1'b1;
                    e_tag = m_tag[win];
                    e_dat = m_dat[win];
                    m_occ[win] = 1'b0;
                    m_ptr = (win + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (f) begin
                        m_occ[i] = 1'b0;
                    end else if (v[i] && exp_rdy[i]) begin
                        m_occ[i] = 1'b1;
                        m_tag[i] = req_tag[i];
                        m_dat[i] = req_wdata[i];
                    end
                end
            end
            chk($sformatf("rnd%0d_cdb_vld", c), 32'(cdb_vld_r), 32'(e_vld));
            chk($sformatf("rnd%0d_cdb_tag", c), 32'(cdb_tag_r), 32'(e_tag));
            chk($sformatf("rnd%0d_cdb_data", c), cdb_wdata_r, e_dat);
            if (cdb_vld_r) begin
                $display("rnd %0d: broadcast tag=%h data=%h", c, cdb_tag_r, cdb_wdata_r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
